// File: rtl/systolic_array_3x3.sv
// systolic_array_3x3: weight-stationary 3x3 MAC array; rows enter on in, weights on w, out1..out3 are bottom-row partial sums
module systolic_array_3x3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [96:0] w,
  input  logic [23:0] in,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3
);
  logic [7:0]  a_q  [3][3];
  logic [7:0]  a_d  [3][3];
  logic [7:0]  a_in [3][3];
  logic [15:0] p_q  [3][3];
  logic [15:0] p_d  [3][3];
  logic [15:0] p_in [3][3];
  logic        unused_w;
  assign unused_w = ^w[96:72];
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        a_in[i][j] = j == 0 ? in[8*i +: 8] : a_q[i][(j+2)%3];
        p_in[i][j] = i == 0 ? 16'd0 : p_q[(i+2)%3][j];
        a_d[i][j]  = en ? a_in[i][j] : a_q[i][j];
        p_d[i][j]  = en ? p_in[i][j] + {8'd0, a_in[i][j]} * {8'd0, w[8*(3*i+j) +: 8]} : p_q[i][j];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '{default: '0};
      p_q <= '{default: '0};
    end else begin
      a_q <= a_d;
      p_q <= p_d;
    end
  end
  assign out1 = p_q[2][0];
  assign out2 = p_q[2][1];
  assign out3 = p_q[2][2];
endmodule

// File: tb/tb_systolic_array_3x3.sv
// tb_systolic_array_3x3: scoreboard bench with directed skewed vectors for systolic_array_3x3
module tb_systolic_array_3x3;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [96:0] w;
  logic [23:0] in;
  logic [15:0] out1, out2, out3;
  typedef struct {
    int          e;
    logic [47:0] v;
    string       nm;
  } exp_t;
  exp_t sb[$];
  int edge_n = 0;
  int checks = 0;
  int passes = 0;
  systolic_array_3x3 dut (
    .clk(clk), .rst(rst), .en(en), .w(w), .in(in),
    .out1(out1), .out2(out2), .out3(out3)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].e <= edge_n) begin
      x = sb.pop_front();
      checks++;
      if ({out1, out2, out3} === x.v) passes++;
      else $display("FAIL %s edge %0d: got %h/%h/%h want %h/%h/%h", x.nm, edge_n,
                    out1, out2, out3, x.v[47:32], x.v[31:16], x.v[15:0]);
    end
  end
  function automatic void push(input int e, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input string nm);
    exp_t x;
    x.e = e;
    x.v = {a, b, c};
    x.nm = nm;
    sb.push_back(x);
  endfunction
  task automatic cyc(input logic [23:0] i, input logic e, input logic r);
    in = i;
    en = e;
    rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic flush();
    for (int k = 0; k < 5; k++) cyc(24'd0, 1'b1, 1'b0);
  endtask
  localparam logic [96:0] W_ID   = {25'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
  localparam logic [96:0] W_ONE  = {25'd0, {9{8'd1}}};
  localparam logic [96:0] W_FF   = {25'd0, {9{8'hff}}};
  localparam logic [96:0] W_SEQ  = {25'd0, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  int t;
  initial begin
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    t = edge_n + 1;
    push(t, 0, 0, 0, "reset0");
    push(t + 1, 0, 0, 0, "reset1");
    push(t + 2, 0, 0, 0, "frozen0");
    push(t + 3, 0, 0, 0, "frozen1");
    cyc(24'hffffff, 1'b1, 1'b1);
    cyc(24'hffffff, 1'b1, 1'b1);
    cyc(24'hffffff, 1'b0, 1'b0);
    cyc(24'hffffff, 1'b0, 1'b0);
    w = W_ID;
    t = edge_n + 1;
    push(t, 0, 0, 0, "id_t");
    push(t + 1, 0, 0, 0, "id_t1");
    push(t + 2, 5, 0, 0, "id_col0");
    push(t + 3, 0, 7, 0, "id_col1");
    push(t + 4, 0, 0, 9, "id_col2");
    push(t + 5, 0, 0, 0, "id_after");
    cyc({8'd0, 8'd0, 8'd5}, 1'b1, 1'b0);
    cyc({8'd0, 8'd7, 8'd0}, 1'b1, 1'b0);
    cyc({8'd9, 8'd0, 8'd0}, 1'b1, 1'b0);
    flush();
    w = W_ONE;
    t = edge_n + 1;
    push(t + 1, 0, 0, 0, "ones_t1");
    push(t + 2, 6, 0, 0, "ones_col0");
    push(t + 3, 0, 6, 0, "ones_col1");
    push(t + 4, 0, 0, 6, "ones_col2");
    push(t + 5, 0, 0, 0, "ones_after");
    cyc({8'd0, 8'd0, 8'd1}, 1'b1, 1'b0);
    cyc({8'd0, 8'd2, 8'd0}, 1'b1, 1'b0);
    cyc({8'd3, 8'd0, 8'd0}, 1'b1, 1'b0);
    flush();
    w = W_SEQ;
    t = edge_n + 1;
    push(t + 1, 0, 0, 0, "stream_t1");
    push(t + 2, 30, 0, 0, "stream_a0");
    push(t + 3, 66, 36, 0, "stream_b0_a1");
    push(t + 4, 0, 81, 42, "stream_b1_a2");
    push(t + 5, 0, 0, 96, "stream_b2");
    push(t + 6, 0, 0, 0, "stream_after");
    cyc({8'd0, 8'd0, 8'd1}, 1'b1, 1'b0);
    cyc({8'd0, 8'd2, 8'd4}, 1'b1, 1'b0);
    cyc({8'd3, 8'd5, 8'd0}, 1'b1, 1'b0);
    cyc({8'd6, 8'd0, 8'd0}, 1'b1, 1'b0);
    flush();
    w = W_FF;
    t = edge_n + 1;
    push(t + 1, 0, 0, 0, "wrap_t1");
    push(t + 2, 16'hfa03, 0, 0, "wrap_col0");
    push(t + 3, 0, 16'hfa03, 0, "wrap_col1");
    push(t + 4, 0, 0, 16'hfa03, "wrap_col2");
    push(t + 5, 0, 0, 0, "wrap_after");
    cyc({8'd0, 8'd0, 8'd255}, 1'b1, 1'b0);
    cyc({8'd0, 8'd255, 8'd0}, 1'b1, 1'b0);
    cyc({8'd255, 8'd0, 8'd0}, 1'b1, 1'b0);
    flush();
    w = W_ID;
    t = edge_n + 1;
    push(t + 2, 5, 0, 0, "hold_pre");
    push(t + 3, 5, 0, 0, "hold0");
    push(t + 4, 5, 0, 0, "hold1");
    push(t + 5, 5, 0, 0, "hold2");
    push(t + 6, 0, 7, 0, "hold_col1");
    push(t + 7, 0, 0, 9, "hold_col2");
    push(t + 8, 0, 0, 0, "hold_after");
    cyc({8'd0, 8'd0, 8'd5}, 1'b1, 1'b0);
    cyc({8'd0, 8'd7, 8'd0}, 1'b1, 1'b0);
    cyc({8'd9, 8'd0, 8'd0}, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(24'hffffff, 1'b0, 1'b0);
    flush();
    t = edge_n + 1;
    push(t + 1, 0, 0, 0, "stall_t1");
    push(t + 2, 0, 0, 0, "stall_s0");
    push(t + 3, 0, 0, 0, "stall_s1");
    push(t + 4, 5, 0, 0, "stall_col0");
    push(t + 5, 0, 7, 0, "stall_col1");
    push(t + 6, 0, 0, 9, "stall_col2");
    push(t + 7, 0, 0, 0, "stall_after");
    cyc({8'd0, 8'd0, 8'd5}, 1'b1, 1'b0);
    cyc({8'd0, 8'd7, 8'd0}, 1'b1, 1'b0);
    cyc(24'hffffff, 1'b0, 1'b0);
    cyc(24'hffffff, 1'b0, 1'b0);
    cyc({8'd9, 8'd0, 8'd0}, 1'b1, 1'b0);
    flush();
    t = edge_n + 1;
    push(t + 1, 0, 0, 0, "mrst_t1");
    push(t + 2, 0, 0, 0, "mrst_edge");
    push(t + 3, 0, 0, 0, "mrst_col1");
    push(t + 4, 0, 0, 0, "mrst_col2");
    push(t + 5, 0, 0, 0, "mrst_after0");
    push(t + 6, 0, 0, 0, "mrst_after1");
    cyc({8'd0, 8'd0, 8'd5}, 1'b1, 1'b0);
    cyc({8'd0, 8'd7, 8'd0}, 1'b1, 1'b1 ^ 1'b1);
    cyc({8'd9, 8'd0, 8'd0}, 1'b1, 1'b1);
    flush();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      checks += sb.size();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
